mem_ctrl_arbiter: RTL and testbench

//  Sole master of the byte-wide unified RAM bus. Arbitrates between an

---
 rtl/mem_ctrl_arbiter_if.sv | 46 ++++
 rtl/mem_ctrl_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_ctrl_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_arbiter_if.sv
`timescale 1ns/1ps
// Bundle of requester, icache-fill and RAM-bus signals around the arbiter.
// Latency: none, wires only.
// Backpressure: none here; the arbiter's ready input pauses the whole bundle.
interface mem_ctrl_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_done_o;
    logic [31:0]       if_inst_o;
    logic              icache_we_o;
    logic [ADDR_W-1:0] icache_waddr_o;
    logic [31:0]       icache_winst_o;
    logic              mem_req_i;
    logic              mem_we_i;
    logic [1:0]        mem_size_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic              mem_done_o;
    logic [31:0]       mem_rdata_o;
    logic [ADDR_W-1:0] ram_a_o;
    logic              ram_wr_o;
    logic [7:0]        ram_dout_o;
    logic [7:0]        ram_din_i;

    // Arbiter side: owns the RAM bus and the done/fill outputs.
    modport master (
        input  if_req_i, if_addr_i,
        output if_done_o, if_inst_o, icache_we_o, icache_waddr_o, icache_winst_o,
        input  mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
        output mem_done_o, mem_rdata_o,
        output ram_a_o, ram_wr_o, ram_dout_o,
        input  ram_din_i
    );

    // Requester / RAM side.
    modport slave (
        output if_req_i, if_addr_i,
        input  if_done_o, if_inst_o, icache_we_o, icache_waddr_o, icache_winst_o,
        output mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
        input  mem_done_o, mem_rdata_o,
        input  ram_a_o, ram_wr_o, ram_dout_o,
        output ram_din_i
    );
endinterface

// File: rtl/mem_ctrl_arbiter.sv
`timescale 1ns/1ps
// Byte-wide RAM bus master arbitrating icache fetches and load/stores (loads/stores win).
// Latency: word read done in cycle after accept+5, word write done after accept+4.
// Backpressure: ready=0 freezes the bus; in-flight read byte is dropped and re-issued.
module mem_ctrl_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ready,
    mem_ctrl_arbiter_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IF_RD  = 3'd1,
        S_MEM_RD = 3'd2,
        S_MEM_WR = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;
    logic [2:0]        n_q;      // bytes in this access: 1, 2 or 4
    logic [2:0]        cnt_q;    // bytes captured (reads) or written (writes)
    logic              pend_q;   // a read address was presented last cycle
    logic              fetch_q;  // current access belongs to the fetch port

    logic              accept;
    logic              is_rd;
    logic [2:0]        rd_issued;
    logic              rd_last;
    logic              wr_last;
    logic [2:0]        req_n;
    logic [2:0]        a_off;

    assign accept    = (state_q == S_IDLE) && ready && (bus.mem_req_i || bus.if_req_i);
    assign is_rd     = (state_q == S_IF_RD) || (state_q == S_MEM_RD);
    assign rd_issued = cnt_q + {2'b00, pend_q};
    // Final byte arrives this cycle: completes the read at the coming edge.
    assign rd_last   = ready && pend_q && ((cnt_q + 3'd1) == n_q);
    assign wr_last   = ready && ((cnt_q + 3'd1) == n_q);
    assign req_n     = (bus.mem_size_i == 2'b00) ? 3'd1 :
                       (bus.mem_size_i == 2'b01) ? 3'd2 : 3'd4;

    // State register; reset aborts any access without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: arbitration in IDLE, byte sequencing, fetch abort, one-cycle DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    if (bus.mem_req_i) begin
                        state_d = bus.mem_we_i ? S_MEM_WR : S_MEM_RD;
                    end else if (bus.if_req_i) begin
                        state_d = S_IF_RD;
                    end
                end
            end
            S_IF_RD: begin
                if (!bus.if_req_i) begin
                    state_d = S_IDLE;
                end else if (rd_last) begin
                    state_d = S_DONE;
                end
            end
            S_MEM_RD: begin
                if (rd_last) begin
                    state_d = S_DONE;
                end
            end
            S_MEM_WR: begin
                if (wr_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch on accept, byte capture/count while the bus runs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            fetch_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.mem_req_i ? bus.mem_addr_i : bus.if_addr_i;
            wdata_q <= bus.mem_wdata_i;
            data_q  <= '0;
            n_q     <= bus.mem_req_i ? req_n : 3'd4;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            fetch_q <= !bus.mem_req_i;
        end else if (is_rd) begin
            if (ready) begin
                if (pend_q) begin
                    data_q[{cnt_q[1:0], 3'b000} +: 8] <= bus.ram_din_i;
                    cnt_q <= cnt_q + 3'd1;
                end
                pend_q <= (rd_issued < n_q);
            end else begin
                // Data for the presented address is lost; re-issue it on resume.
                pend_q <= 1'b0;
            end
        end else if (state_q == S_MEM_WR) begin
            if (ready) begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    // Output decode: RAM bus drive, done pulses and fill port.
    always_comb begin
        a_off = 3'd0;
        if (is_rd) begin
            a_off = rd_issued;
        end else if (state_q == S_MEM_WR) begin
            a_off = cnt_q;
        end
        bus.ram_a_o        = addr_q + ADDR_W'(a_off);
        bus.ram_wr_o       = (state_q == S_MEM_WR) && ready;
        bus.ram_dout_o     = bus.ram_wr_o ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
        bus.if_done_o      = (state_q == S_DONE) && ready && fetch_q;
        bus.mem_done_o     = (state_q == S_DONE) && ready && !fetch_q;
        bus.icache_we_o    = bus.if_done_o;
        bus.icache_waddr_o = addr_q;
        bus.icache_winst_o = data_q;
        bus.if_inst_o      = data_q;
        bus.mem_rdata_o    = data_q;
    end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_ctrl_arbiter with a byte RAM model behind the bus.
// Latency: checks done-pulse cycle counts against hand-derived values.
// Backpressure: exercises ready stalls, fetch abort and async reset mid-store.
module tb_mem_ctrl_arbiter;

    logic clk;
    logic rst;
    logic ready;

    mem_ctrl_arbiter_if #(.ADDR_W(32)) bus ();

    mem_ctrl_arbiter #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .ready (ready),
        .bus   (bus)
    );

    logic [7:0]  ram [0:1048575];
    logic [31:0] wr_a [$];
    logic [7:0]  wr_d [$];
    int          if_cnt;
    int          ice_cnt;
    int          n_chk;
    int          n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read (1-cycle latency), write on strobe, write log.
    always @(posedge clk) begin
        if (bus.ram_wr_o) begin
            ram[bus.ram_a_o[19:0]] <= bus.ram_dout_o;
            wr_a.push_back(bus.ram_a_o);
            wr_d.push_back(bus.ram_dout_o);
        end
        bus.ram_din_i <= ram[bus.ram_a_o[19:0]];
    end

    // Count fetch-done and icache-fill pulses.
    always @(posedge clk) begin
        if (bus.if_done_o)   if_cnt  <= if_cnt + 1;
        if (bus.icache_we_o) ice_cnt <= ice_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First edge is the accept edge; lat counts edges after it up to the done cycle.
    task automatic wait_done(input bit fetch, output int lat);
        lat = -1;
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (fetch ? bus.if_done_o : bus.mem_done_o) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat;
    int if_base;
    int ice_base;

    initial begin
        rst = 1'b0;
        ready = 1'b1;
        bus.if_req_i = 1'b0;
        bus.if_addr_i = '0;
        bus.mem_req_i = 1'b0;
        bus.mem_we_i = 1'b0;
        bus.mem_size_i = 2'b00;
        bus.mem_addr_i = '0;
        bus.mem_wdata_i = '0;
        if_cnt = 0;
        ice_cnt = 0;
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 1048576; i++) ram[i] = 8'h00;
        ram[20'h01000] = 8'h13; ram[20'h01001] = 8'h00;
        ram[20'h01002] = 8'h50; ram[20'h01003] = 8'h00;
        ram[20'h01004] = 8'h12; ram[20'h01005] = 8'h34;
        ram[20'h01006] = 8'h56; ram[20'h01007] = 8'h78;
        ram[20'h02003] = 8'h80;
        ram[20'hFFFFF] = 8'hAB;
        ram[20'h00000] = 8'hCD;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_wr",   bus.ram_wr_o,       0);
        chk("rst_ram_a",    bus.ram_a_o,        0);
        chk("rst_if_done",  bus.if_done_o,      0);
        chk("rst_mem_done", bus.mem_done_o,     0);
        chk("rst_rdata",    bus.mem_rdata_o,    0);
        chk("rst_inst",     bus.if_inst_o,      0);
        chk("rst_icache_we",bus.icache_we_o,    0);
        chk("rst_waddr",    bus.icache_waddr_o, 0);
        step();
        rst = 1'b1;

        // Word fetch 0x1000
        bus.if_addr_i = 32'h1000;
        bus.if_req_i = 1'b1;
        wait_done(1'b1, lat);
        chk("f1_lat",      lat, 5);
        chk("f1_inst",     bus.if_inst_o,      32'h00500013);
        chk("f1_icwe",     bus.icache_we_o,    1);
        chk("f1_waddr",    bus.icache_waddr_o, 32'h1000);
        chk("f1_winst",    bus.icache_winst_o, 32'h00500013);
        chk("f1_no_mdone", bus.mem_done_o,     0);
        step();
        bus.if_req_i = 1'b0;
        @(negedge clk);
        chk("f1_pulse_end", bus.if_done_o, 0);
        chk("f1_inst_hold", bus.if_inst_o, 32'h00500013);

        // Simultaneous requests: load byte 0x2003 wins, then fetch
        step();
        bus.mem_req_i = 1'b1;
        bus.mem_we_i = 1'b0;
        bus.mem_size_i = 2'b00;
        bus.mem_addr_i = 32'h2003;
        bus.if_addr_i = 32'h1000;
        bus.if_req_i = 1'b1;
        wait_done(1'b0, lat);
        chk("pri_lat",     lat, 2);
        chk("pri_rdata",   bus.mem_rdata_o, 32'h00000080);
        chk("pri_no_ifd",  bus.if_done_o, 0);
        step();
        bus.mem_req_i = 1'b0;
        wait_done(1'b1, lat);
        chk("pri_f_lat",   lat, 5);
        chk("pri_f_inst",  bus.if_inst_o, 32'h00500013);
        step();
        bus.if_req_i = 1'b0;

        // Store word 0xDEADBEEF @0x30000
        wr_a.delete();
        wr_d.delete();
        if_base = if_cnt;
        bus.mem_req_i = 1'b1;
        bus.mem_we_i = 1'b1;
        bus.mem_size_i = 2'b10;
        bus.mem_addr_i = 32'h30000;
        bus.mem_wdata_i = 32'hDEADBEEF;
        wait_done(1'b0, lat);
        chk("st_lat",    lat, 4);
        chk("st_nwr",    wr_a.size(), 4);
        if (wr_a.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("st_a%0d", k), wr_a[k], 32'h30000 + k);
                chk($sformatf("st_d%0d", k), wr_d[k], (32'hDEADBEEF >> (8 * k)) & 32'hFF);
            end
        end
        step();
        bus.mem_req_i = 1'b0;
        bus.mem_we_i = 1'b0;
        chk("st_no_ifd", if_cnt, if_base);

        // Fetch 0x1004 with ready low for 3 edges after the 2nd capture
        wr_a.delete();
        wr_d.delete();
        bus.if_addr_i = 32'h1004;
        bus.if_req_i = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready = 1'b1;
        lat = -1;
        for (int k = 7; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.if_done_o) begin
                lat = k;
                break;
            end
        end
        chk("stall_lat",  lat, 9);
        chk("stall_inst", bus.if_inst_o, 32'h78563412);
        chk("stall_nowr", wr_a.size(), 0);
        step();
        bus.if_req_i = 1'b0;

        // Fetch abort after 2 bytes, then load accepted right away
        if_base = if_cnt;
        ice_base = ice_cnt;
        bus.if_addr_i = 32'h1000;
        bus.if_req_i = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 bus.if_req_i = 1'b0;
        @(posedge clk);
        #1;
        bus.mem_req_i = 1'b1;
        bus.mem_we_i = 1'b0;
        bus.mem_size_i = 2'b00;
        bus.mem_addr_i = 32'h2003;
        wait_done(1'b0, lat);
        chk("ab_lat",   lat, 2);
        chk("ab_rdata", bus.mem_rdata_o, 32'h00000080);
        chk("ab_ifd",   if_cnt, if_base);
        chk("ab_icwe",  ice_cnt, ice_base);
        step();
        bus.mem_req_i = 1'b0;

        // Half load across the address wrap
        bus.mem_req_i = 1'b1;
        bus.mem_size_i = 2'b01;
        bus.mem_addr_i = 32'hFFFFFFFF;
        wait_done(1'b0, lat);
        chk("wrap_lat",   lat, 3);
        chk("wrap_rdata", bus.mem_rdata_o, 32'h0000CDAB);
        step();
        bus.mem_req_i = 1'b0;
        @(negedge clk);
        chk("wrap_hold",  bus.mem_rdata_o, 32'h0000CDAB);
        step();

        // Size 11 treated as word
        bus.mem_req_i = 1'b1;
        bus.mem_size_i = 2'b11;
        bus.mem_addr_i = 32'h1000;
        wait_done(1'b0, lat);
        chk("sz3_lat",   lat, 5);
        chk("sz3_rdata", bus.mem_rdata_o, 32'h00500013);
        step();
        bus.mem_req_i = 1'b0;

        // Reset mid-store after 2 bytes
        wr_a.delete();
        wr_d.delete();
        bus.mem_req_i = 1'b1;
        bus.mem_we_i = 1'b1;
        bus.mem_size_i = 2'b10;
        bus.mem_addr_i = 32'h30010;
        bus.mem_wdata_i = 32'h11223344;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mr_ram_wr", bus.ram_wr_o,       0);
        chk("mr_ram_a",  bus.ram_a_o,        0);
        chk("mr_dout",   bus.ram_dout_o,     0);
        chk("mr_rdata",  bus.mem_rdata_o,    0);
        chk("mr_waddr",  bus.icache_waddr_o, 0);
        chk("mr_mdone",  bus.mem_done_o,     0);
        bus.mem_req_i = 1'b0;
        bus.mem_we_i = 1'b0;
        step();
        rst = 1'b1;
        chk("mr_nwr",    wr_a.size(), 2);
        chk("mr_byte2",  ram[20'h30012], 8'h00);
        bus.if_addr_i = 32'h1000;
        bus.if_req_i = 1'b1;
        wait_done(1'b1, lat);
        chk("mr_idle_lat", lat, 5);
        step();
        bus.if_req_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
